bios_loadable_rom: RTL
======================

// Module: bios_loadable_rom
// PURPOSE
//  Parametrised BIOS/code memory for the i281 CPU. Holds DEPTH words of WIDTH bits.
//  Reset loads the factory image. A valid/ready word stream can reload it at run time,
//  followed by a checksum word. The CPU is held while a load is in progress.
//  Sits between the boot/debug interface and the CPU instruction-fetch path.
// PARAMETERS
//  WIDTH      16                 instruction word width, bits
//  DEPTH      16                 number of words; power of two, >=2
//  AW         $clog2(DEPTH)      address width, derived; do not override
//  INIT_IMAGE {DEPTH{16'h0000}}  factory image, WIDTH*DEPTH bits; word i at [i*WIDTH +: WIDTH]
// PORTS
//  clock        in   1      system clock, rising edge
//  reset_n      in   1      asynchronous active-low reset
//  rd_addr      in   AW     CPU fetch address
//  rd_data      out  WIDTH  mem[rd_addr]; combinational read
//  load_start   in   1      pulse: begin reload (accepted only in IDLE)
//  load_valid   in   1      load_data is valid this cycle
//  load_data    in   WIDTH  payload word or checksum word
//  load_ready   out  1      block accepts load_data this cycle
//  cpu_hold     out  1      CPU must stall; high in LOAD and CHECK
//  load_done    out  1      1-cycle pulse when a load completes, good or bad
//  load_err     out  1      sticky: last checksum mismatched; cleared by next load_start
//  word_count   out  AW+1   payload words accepted in the current or last load
// BEHAVIOUR
//  Reset (async assert, sync release): mem[i] <= INIT_IMAGE word i for all i.
//   State=IDLE. load_ready=0, cpu_hold=0, load_done=0, load_err=0, word_count=0.
//  A transfer happens when load_valid && load_ready on a rising edge.
//  FSM states:
//   IDLE: load_ready=0. A load_start moves to LOAD. The same edge clears load_err,
//     word_count and the running checksum. load_valid is ignored in IDLE.
//   LOAD: load_ready=1. Each transfer writes mem[word_count] <= load_data.
//     It also increments word_count and does csum <= csum ^ load_data.
//     The write is visible on rd_data the next cycle.
//     On the transfer with word_count==DEPTH-1, move to CHECK.
//   CHECK: load_ready=1. The next transfer is the checksum word.
//     It is not written to mem. Set load_err = (load_data != csum).
//     Pulse load_done for 1 cycle. Move to IDLE.
//  cpu_hold = (state==LOAD || state==CHECK). It is registered state decode, not data-dependent.
//  load_start in LOAD or CHECK is ignored; the load continues.
//  A mismatched checksum does not roll back mem. The new contents remain, and load_err flags them.
//  word_count saturates at DEPTH. It holds its value in IDLE until the next load_start.
//  Address wrap: rd_addr is AW bits, so there is no out-of-range read.
//  A reset mid-load aborts the load. mem reverts to INIT_IMAGE and all outputs take reset values.
//  Gaps (load_valid=0) in LOAD or CHECK are allowed indefinitely and cause no state change.
//  Read/write same cycle, same address: rd_data shows the old word until the edge.
// TESTING
//  1 Reset, default params, INIT_IMAGE word0=16'h5C10, word15=16'h0000
//    -> rd_addr=0 gives 16'h5C10; cpu_hold=0, load_ready=0.
//  2 load_start, then 16 words 16'h0001..16'h0010 with no gaps, then checksum 16'h0010
//    (XOR of 1..16) -> mem[k]=k+1; load_done pulses once; load_err=0; word_count=16; cpu_hold falls.
//  3 Same payload, checksum 16'hFFFF -> load_err=1, mem keeps the new words.
//    The next load_start clears load_err.
//  4 Assert reset_n=0 after 5 of 16 words -> all outputs at reset values within the same cycle;
//    rd_addr=0 returns 16'h5C10.
//  5 Random load_valid gaps (50%), plus a load_start pulse mid-load -> load finishes unchanged;
//    exactly 17 transfers; no extra writes.
//  6 DEPTH=32, WIDTH=8: full load plus checksum -> word_count=32; mem[31] is correct;
//    mem[0] is not overwritten by wrap.

Source files
------------

// File: rtl/bios_loadable_rom.sv
// bios_loadable_rom: DEPTH x WIDTH code memory for the i281 CPU.
// Reset restores the factory image; a valid/ready word stream followed by an
// XOR checksum word can reload it at run time while the CPU is held.
module bios_loadable_rom #(
  parameter int unsigned                   WIDTH      = 16,
  parameter int unsigned                   DEPTH      = 16,
  parameter int unsigned                   AW         = $clog2(DEPTH),
  parameter logic [WIDTH*DEPTH-1:0]        INIT_IMAGE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [AW:0]      word_count
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] csum_q, csum_d;
  logic [CW-1:0]    count_d;
  logic             err_d;
  logic             done_d;
  logic             wr_en;
  logic             xfer;

  // A word moves only when the stream offers it and we are accepting.
  assign xfer = load_valid && load_ready;

  // Combinational fetch path; a write lands on the edge, so the old word shows until then.
  assign rd_data = mem[rd_addr];

  // Next-state, checksum, counter and write-enable decode.
  always_comb begin
    state_d = state_q;
    csum_d  = csum_q;
    count_d = word_count;
    err_d   = load_err;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          csum_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          wr_en   = 1'b1;
          csum_d  = csum_q ^ load_data;
          count_d = (word_count == CW'(DEPTH)) ? word_count : word_count + CW'(1);
          if (word_count == CW'(DEPTH - 1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (xfer) begin
          err_d   = (load_data != csum_q);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, status and handshake registers; ready/hold are pure state decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      csum_q     <= '0;
      word_count <= '0;
      load_err   <= 1'b0;
      load_done  <= 1'b0;
      load_ready <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      state_q    <= state_d;
      csum_q     <= csum_d;
      word_count <= count_d;
      load_err   <= err_d;
      load_done  <= done_d;
      load_ready <= (state_d != IDLE);
      cpu_hold   <= (state_d == LOAD) || (state_d == CHECK);
    end
  end

  // Memory array: reset restores the factory image, loads overwrite in order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= INIT_IMAGE[i*WIDTH +: WIDTH];
      end
    end else if (wr_en) begin
      mem[word_count[AW-1:0]] <= load_data;
    end
  end

endmodule
